// File: rtl/div_pkg.sv
// Purpose : shared FSM encoding and constants for the sequential restoring divider.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents:
//   STATE_W   - FSM state register width (3; codes 4..7 are unused and recover to IDLE)
//   state_t   - IDLE=0, SHIFT=1, CHECK=2, END=3
//   ones_mask - all-ones value of a given width, used as the divide-by-zero quotient
package div_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    END   = 3'd3
  } state_t;

  // All-ones constant for widths up to 64 bits; callers cast down to their width.
  function automatic logic [63:0] ones_mask(input int w);
    logic [63:0] m;
    m = '1;
    if (w < 64) begin
      m = (64'd1 << w) - 64'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/div_seq_ctrl.sv
// Purpose : control FSM of the sequential divider; turns cnt==0, diff MSB and divisor==0 into strobes.
// Latency : done in the 2*WIDTH+1-th cycle after accept (normal), 2nd cycle (divide-by-zero).
// Backpr. : none; init_in is only honoured in IDLE, anything else is dropped.
//
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   init_in         - start strobe (sampled in IDLE only)
//   div0            - raw divisor is zero (meaningful with init_in)
//   cnt_zero        - iteration counter has reached zero
//   diff_msb        - sign bit of A - B (1: trial subtraction failed, restore)
//   load/shift/sub  - datapath strobes: capture operands / shift {A,Q} / commit A-B and set Q[0]
//   fin             - datapath strobe: register quotient/remainder/dv0
//   busy, done      - registered status outputs
import div_pkg::*;

module div_seq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic init_in,
  input  logic div0,
  input  logic cnt_zero,
  input  logic diff_msb,
  output logic load,
  output logic shift,
  output logic sub,
  output logic fin,
  output logic busy,
  output logic done
);

  state_t state;

  // The normal path commits results on the CHECK->END edge so they appear
  // together with done. The divide-by-zero path enters END straight from IDLE
  // with done still low and commits during its first END cycle; that extra
  // END cycle is what gives the two-cycle divide-by-zero latency.
  always_comb begin
    load  = (state == IDLE) && init_in;
    shift = (state == SHIFT);
    sub   = (state == CHECK) && !diff_msb;
    fin   = ((state == CHECK) && cnt_zero) || ((state == END) && !done);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (init_in) begin
            busy  <= 1'b1;
            state <= div0 ? END : SHIFT;
          end else begin
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          state <= CHECK;
        end
        CHECK: begin
          if (cnt_zero) begin
            state <= END;
            done  <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        END: begin
          if (done) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            // first END cycle of a divide-by-zero: results committed now
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Purpose : parametrised sequential restoring divider (quotient, remainder, divide-by-zero flag).
// Latency : done 2*WIDTH+1 cycles after accept (17 for WIDTH=8); 2 cycles for divide-by-zero.
// Backpr. : none; init_in outside IDLE is ignored, held init_in restarts right after done.
//
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   init_in             - start strobe, sampled only while idle
//   dividend, divisor   - WIDTH-bit operands captured on accept
//   busy                - high from the cycle after accept through the done cycle
//   done                - one-cycle pulse, results valid from this cycle
//   quotient, remainder - results, held until the next completion
//   dv0                 - divide-by-zero flag, valid with done, cleared on next accept
//
// Build option: define DIV_SIGNED_EN for two's-complement operands (magnitudes are
// divided, quotient negated when operand signs differ, remainder follows dividend sign).
import div_pkg::*;

module div_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_in,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dv0
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Q_ONES = WIDTH'(ones_mask(WIDTH));

  logic [WIDTH:0]   a;         // partial remainder, one guard bit
  logic [WIDTH-1:0] q;         // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] b;         // divisor (magnitude in signed builds)
  logic [CNT_W-1:0] cnt;
  logic             dv0_pend;  // captured divisor==0, published at completion

  logic             load, shift, sub, fin;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_next, a_low_next;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] res_q, res_r, r_mag;

  // Trial subtraction; MSB set means A < B and the iteration restores.
  assign diff = a - {1'b0, b};

  // Values A/Q take at the end of this cycle's CHECK, so a completion on the
  // last CHECK can publish them in the same edge.
  assign q_next     = sub ? {q[WIDTH-1:1], 1'b1} : q;
  assign a_low_next = sub ? diff[WIDTH-1:0] : a[WIDTH-1:0];

  // On the divide-by-zero path Q still holds the captured dividend.
  assign r_mag = dv0_pend ? q : a_low_next;

`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  // Most-negative / -1: magnitude quotient is 2^(WIDTH-1), which reads back
  // as most-negative without negation, remainder is 0.
  assign res_q = dv0_pend ? Q_ONES : (q_neg ? -q_next : q_next);
  assign res_r = r_neg ? -r_mag : r_mag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign res_q   = dv0_pend ? Q_ONES : q_next;
  assign res_r   = r_mag;
`endif

  div_seq_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init_in  (init_in),
    .div0     (divisor == '0),
    .cnt_zero (cnt == '0),
    .diff_msb (diff[WIDTH]),
    .load     (load),
    .shift    (shift),
    .sub      (sub),
    .fin      (fin),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      a         <= '0;
      q         <= '0;
      b         <= '0;
      cnt       <= '0;
      dv0_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dv0       <= 1'b0;
    end else begin
      if (load) begin
        a        <= '0;
        q        <= dvd_mag;
        b        <= dvs_mag;
        cnt      <= CNT_W'(WIDTH);
        dv0_pend <= (divisor == '0);
        dv0      <= 1'b0;
      end
      if (shift) begin
        a   <= {a[WIDTH-1:0], q[WIDTH-1]};
        q   <= {q[WIDTH-2:0], 1'b0};
        cnt <= cnt - CNT_W'(1);
      end
      if (sub) begin
        a    <= diff;
        q[0] <= 1'b1;
      end
      if (fin) begin
        quotient  <= res_q;
        remainder <= res_r;
        dv0       <= dv0_pend;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Purpose : directed self-checking bench for div_seq_param at WIDTH=8.
// Latency : done expected 17 cycles after accept (2 for divide-by-zero).
// Backpr. : held and mid-operation init_in strobes exercised.
module tb_div_seq_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init_in = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, dv0;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_in   (init_in),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dv0       (dv0)
  );

  // Present operands and strobe init_in across one rising edge (the accept edge).
  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    init_in  = 1'b1;
    @(posedge clk);
    #1 init_in = 1'b0;
  endtask

  // Count cycles after the accept edge until done (sampled on falling edges).
  // lat stays 0 if done never arrives within the budget.
  task automatic wait_done(output int lat, output bit all_busy);
    lat = 0;
    all_busy = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) all_busy = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (quotient !== 8'd0) begin n_bad++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    n_cmp++; if (remainder !== 8'd0) begin n_bad++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL reset_dv0 got %0b want 0", dv0); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    bit all_busy;
    start_op(8'd100, 8'd7);
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL basic_latency got %0d want 17", lat); end
    n_cmp++; if (all_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_span got %0b want 1", all_busy); end
    n_cmp++; if (quotient !== 8'd14) begin n_bad++; $display("FAIL basic_quotient got %0d want 14", quotient); end
    n_cmp++; if (remainder !== 8'd2) begin n_bad++; $display("FAIL basic_remainder got %0d want 2", remainder); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL basic_dv0 got %0b want 0", dv0); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %0b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %0b want 0", busy); end
    n_cmp++; if (quotient !== 8'd14) begin n_bad++; $display("FAIL basic_hold got %0d want 14", quotient); end
  endtask

  task automatic test_div_zero;
    int lat;
    bit all_busy;
    start_op(8'd55, 8'd0);
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dv0_latency got %0d want 2", lat); end
    n_cmp++; if (all_busy !== 1'b1) begin n_bad++; $display("FAIL dv0_busy_span got %0b want 1", all_busy); end
    n_cmp++; if (dv0 !== 1'b1) begin n_bad++; $display("FAIL dv0_flag got %0b want 1", dv0); end
    n_cmp++; if (quotient !== 8'd255) begin n_bad++; $display("FAIL dv0_quotient got %0d want 255", quotient); end
    n_cmp++; if (remainder !== 8'd55) begin n_bad++; $display("FAIL dv0_remainder got %0d want 55", remainder); end
    @(negedge clk);
    n_cmp++; if (dv0 !== 1'b1) begin n_bad++; $display("FAIL dv0_hold got %0b want 1", dv0); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit all_busy;
    start_op(8'd200, 8'd9);
    repeat (7) @(negedge clk);  // into the 4th shift/check pair
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %0b want 0", done); end
    n_cmp++; if (quotient !== 8'd0) begin n_bad++; $display("FAIL rstmid_quotient got %0d want 0", quotient); end
    n_cmp++; if (remainder !== 8'd0) begin n_bad++; $display("FAIL rstmid_remainder got %0d want 0", remainder); end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got %0b want 0", done); end
    end
    start_op(8'd200, 8'd9);
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL rstmid_latency got %0d want 17", lat); end
    n_cmp++; if (quotient !== 8'd22) begin n_bad++; $display("FAIL rstmid_quotient2 got %0d want 22", quotient); end
    n_cmp++; if (remainder !== 8'd2) begin n_bad++; $display("FAIL rstmid_remainder2 got %0d want 2", remainder); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit all_busy;
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 8'd1;
    init_in  = 1'b1;
    @(posedge clk);
    #1;
    dividend = 8'd3;
    divisor  = 8'd200;
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL b2b_latency1 got %0d want 17", lat); end
    n_cmp++; if (quotient !== 8'd255) begin n_bad++; $display("FAIL b2b_quotient1 got %0d want 255", quotient); end
    n_cmp++; if (remainder !== 8'd0) begin n_bad++; $display("FAIL b2b_remainder1 got %0d want 0", remainder); end
    @(posedge clk);
    @(negedge clk);
    // IDLE cycle right after done: held init_in is accepted on the coming edge
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_done got %0b want 0", done); end
    @(posedge clk);
    #1 init_in = 1'b0;
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL b2b_latency2 got %0d want 17", lat); end
    n_cmp++; if (all_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy2 got %0b want 1", all_busy); end
    n_cmp++; if (quotient !== 8'd0) begin n_bad++; $display("FAIL b2b_quotient2 got %0d want 0", quotient); end
    n_cmp++; if (remainder !== 8'd3) begin n_bad++; $display("FAIL b2b_remainder2 got %0d want 3", remainder); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL b2b_dv0 got %0b want 0", dv0); end
  endtask

  task automatic test_ignore_busy;
    int first_lat;
    int n_done;
    start_op(8'd20, 8'd3);
    first_lat = 0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_lat == 0) first_lat = c;
      end
      if (c == 3) begin
        dividend = 8'd9;
        divisor  = 8'd9;
        init_in  = 1'b1;
      end
      if (c == 4) init_in = 1'b0;
      if (c == 17) begin
        n_cmp++; if (quotient !== 8'd6) begin n_bad++; $display("FAIL ign_quotient got %0d want 6", quotient); end
        n_cmp++; if (remainder !== 8'd2) begin n_bad++; $display("FAIL ign_remainder got %0d want 2", remainder); end
      end
    end
    n_cmp++; if (first_lat !== 17) begin n_bad++; $display("FAIL ign_latency got %0d want 17", first_lat); end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL ign_done_count got %0d want 1", n_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy_end got %0b want 0", busy); end
    n_cmp++; if (quotient !== 8'd6) begin n_bad++; $display("FAIL ign_quotient_end got %0d want 6", quotient); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    int lat;
    bit all_busy;
    start_op(8'h9C, 8'd7);       // -100 / 7
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL sgn_latency1 got %0d want 17", lat); end
    n_cmp++; if (quotient !== 8'hF2) begin n_bad++; $display("FAIL sgn_quotient1 got %0h want f2", quotient); end
    n_cmp++; if (remainder !== 8'hFE) begin n_bad++; $display("FAIL sgn_remainder1 got %0h want fe", remainder); end
    start_op(8'h80, 8'hFF);      // -128 / -1
    wait_done(lat, all_busy);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL sgn_latency2 got %0d want 17", lat); end
    n_cmp++; if (quotient !== 8'h80) begin n_bad++; $display("FAIL sgn_quotient2 got %0h want 80", quotient); end
    n_cmp++; if (remainder !== 8'h00) begin n_bad++; $display("FAIL sgn_remainder2 got %0h want 0", remainder); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL sgn_dv0 got %0b want 0", dv0); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_reset_mid;
    test_back_to_back;
    test_ignore_busy;
`ifdef DIV_SIGNED_EN
    test_signed;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
Name: div_seq_param

Overview:
- Parametrised sequential restoring divider. Integrated FSM plus datapath; successor to the fixed-width divider control/ASM pair.
- Takes a WIDTH-bit dividend and divisor on an init_in strobe, produces quotient and remainder after a fixed latency, then pulses done.
- Flags divide-by-zero explicitly. Used by the arithmetic units wherever a multi-cycle divide is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- init_in  in  1  start strobe; sampled only in IDLE.
- dividend  in  WIDTH  numerator; captured on accepted init_in.
- divisor  in  WIDTH  denominator; captured on accepted init_in.
- busy  out  1  high from the cycle after accept until the done cycle inclusive.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- dv0  out  1  divide-by-zero flag; valid with done, held like the results.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; busy=0, done=0, dv0=0, quotient=0, remainder=0, counter=0.
- Reset mid-operation aborts immediately. No done is issued and the results read as reset values.
- Internal registers:
  - A: WIDTH+1-bit partial remainder.
  - Q: WIDTH-bit, dividend/quotient shift register.
  - B: WIDTH-bit divisor.
  - cnt: CNT_W-bit iteration counter.
- IDLE:
  - On init_in=1: A<=0, Q<=dividend, B<=divisor, cnt<=WIDTH.
  - If divisor==0, go to END; otherwise go to SHIFT.
  - init_in=0: stay in IDLE.
- SHIFT: {A,Q} <= {A,Q}<<1, Q[0]<=0, cnt<=cnt-1. Go to CHECK.
- CHECK:
  - Compute diff = A - {1'b0,B} at WIDTH+1 bits.
  - diff MSB==0: A<=diff and Q[0]<=1.
  - diff MSB==1: A and Q[0] are unchanged (restore).
  - If cnt==0, go to END; otherwise go to SHIFT.
- END:
  - done=1 for exactly one cycle.
  - quotient<=Q and remainder<=A[WIDTH-1:0], registered on entry so they are visible in the done cycle.
  - Next state is IDLE.
- Divide-by-zero path:
  - dv0=1, quotient=all ones, remainder=dividend.
  - Latency is 2 cycles from accept to done; no iterations run.
- Normal latency: done asserts 2*WIDTH+1 cycles after the accepting edge (WIDTH SHIFT/CHECK pairs, then END).
- init_in while not in IDLE is ignored; there is no queuing.
- init_in held high: a new operation is accepted on the first IDLE cycle after done, i.e. back-to-back operation.
- dv0 clears on the next accepted start.
- State encoding: IDLE=0, SHIFT=1, CHECK=2, END=3, unused=4..7. Unused states go to IDLE with outputs inactive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at capture.
  - Quotient sign = dividend sign XOR divisor sign; remainder takes the dividend's sign. Negation is applied in END.
  - Most-negative / -1 gives quotient = most-negative, remainder = 0, dv0 = 0.
  - Divide-by-zero behaves as in unsigned mode.
  - Latency is unchanged.
- Undefined: operands are unsigned and there is no negation logic.

Decomposition:
- Package div_pkg holds:
  - state localparams IDLE/SHIFT/CHECK/END and the state width (3);
  - the quotient all-ones constant function of WIDTH used for divide-by-zero.
- One natural sub-module: div_seq_ctrl (the FSM, decoding cnt==0, diff MSB and divisor==0 into shift/load/sub strobes).
- The datapath stays in div_seq_param.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, pulse init_in -> done exactly 17 cycles after accept; quotient=14, remainder=2, dv0=0; busy high for the 17 cycles up to and including done.
- WIDTH=8, dividend=55, divisor=0 -> done 2 cycles after accept; dv0=1, quotient=255, remainder=55.
- WIDTH=8, 255/1 then, with init_in held high, 3/200 back-to-back -> first op 255 r0; second op accepted in the IDLE cycle right after done, giving 0 r3 with dv0=0.
- Reset mid-operation: rst=0 at iteration 4 of 200/9 -> next cycle busy=0, done=0, quotient=0, remainder=0; a following 200/9 yields 22 r2.
- init_in pulses during busy (20/3 in flight, spurious 9/9 strobe) -> result 6 r2, a single done, no second op.
- DIV_SIGNED_EN, WIDTH=8:
  - -100/7 -> quotient=-14, remainder=-2.
  - -128/-1 -> quotient=-128, remainder=0.
  - Latency is 17 cycles in both cases.
